// File: rtl/buf_port_arbiter_if.sv
// Bundle of the AHB-side, flash-FSM-side and buffer-RAM signals around buf_port_arbiter.
// The arbiter uses the slave modport; the requesters and RAM environment use master.
interface buf_port_arbiter_if;
    logic        ahb_req;
    logic        ahb_we;
    logic [7:0]  ahb_addr;
    logic [3:0]  ahb_be;
    logic [31:0] ahb_wdata;
    logic        ahb_gnt;
    logic        ahb_rvalid;
    logic [31:0] ahb_rdata;

    logic        f_req;
    logic        f_we;
    logic [9:0]  f_addr;
    logic [7:0]  f_wdata;
    logic        f_gnt;
    logic        f_rvalid;
    logic [7:0]  f_rdata;
    logic        f_burst;

    logic        ram_cs;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    modport slave (
        input  ahb_req, ahb_we, ahb_addr, ahb_be, ahb_wdata,
        input  f_req, f_we, f_addr, f_wdata, f_burst,
        input  ram_rdata,
        output ahb_gnt, ahb_rvalid, ahb_rdata,
        output f_gnt, f_rvalid, f_rdata,
        output ram_cs, ram_we, ram_addr, ram_be, ram_wdata
    );

    modport master (
        output ahb_req, ahb_we, ahb_addr, ahb_be, ahb_wdata,
        output f_req, f_we, f_addr, f_wdata, f_burst,
        output ram_rdata,
        input  ahb_gnt, ahb_rvalid, ahb_rdata,
        input  f_gnt, f_rvalid, f_rdata,
        input  ram_cs, ram_we, ram_addr, ram_be, ram_wdata
    );
endinterface

// File: rtl/buf_port_arbiter.sv
// Two-port arbiter in front of a single-port 256x32 buffer RAM: AHB word port vs. flash-FSM
// byte port, round-robin normally, flash-priority with bounded AHB starvation during bursts.
module buf_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    buf_port_arbiter_if.slave bus
);

    localparam int            CW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
    localparam logic [0:0]    LAST_AHB   = 1'b0;
    localparam logic [0:0]    LAST_MFSM  = 1'b1;

    logic [0:0]    last_grant_q, last_grant_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          ahb_pend_q, ahb_pend_d;
    logic          f_pend_q, f_pend_d;
    logic [1:0]    f_lane_q, f_lane_d;
    logic [31:0]   ahb_hold_q, ahb_hold_d;
    logic [7:0]    f_hold_q, f_hold_d;

    logic          ahb_gnt;
    logic          f_gnt;
    logic [7:0]    f_lane_data;

    // Grants are held off while reset is asserted so every RAM-facing output reads zero.
    always_comb begin
        ahb_gnt = 1'b0;
        f_gnt   = 1'b0;
        if (HRESETn) begin
            if (bus.ahb_req && bus.f_req) begin
                if (bus.f_burst) begin
                    if (starve_q == STARVE_LIM) ahb_gnt = 1'b1;
                    else                        f_gnt   = 1'b1;
                end else if (last_grant_q == LAST_MFSM) begin
                    ahb_gnt = 1'b1;
                end else begin
                    f_gnt = 1'b1;
                end
            end else begin
                ahb_gnt = bus.ahb_req;
                f_gnt   = bus.f_req;
            end
        end
    end

    always_comb begin
        bus.ram_cs    = ahb_gnt | f_gnt;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = 8'h00;
        bus.ram_be    = 4'h0;
        bus.ram_wdata = 32'h0;
        if (ahb_gnt) begin
            bus.ram_we    = bus.ahb_we;
            bus.ram_addr  = bus.ahb_addr;
            bus.ram_be    = bus.ahb_we ? bus.ahb_be : 4'h0;
            bus.ram_wdata = bus.ahb_wdata;
        end else if (f_gnt) begin
            bus.ram_we    = bus.f_we;
            bus.ram_addr  = bus.f_addr[9:2];
            bus.ram_be    = bus.f_we ? (4'b0001 << bus.f_addr[1:0]) : 4'h0;
            bus.ram_wdata = {4{bus.f_wdata}};
        end
    end

    always_comb begin
        case (f_lane_q)
            2'd0:    f_lane_data = bus.ram_rdata[7:0];
            2'd1:    f_lane_data = bus.ram_rdata[15:8];
            2'd2:    f_lane_data = bus.ram_rdata[23:16];
            default: f_lane_data = bus.ram_rdata[31:24];
        endcase
    end

    // The starve count only means something while a burst is starving a waiting AHB request.
    always_comb begin
        last_grant_d = last_grant_q;
        if (ahb_gnt)    last_grant_d = LAST_AHB;
        else if (f_gnt) last_grant_d = LAST_MFSM;

        starve_d = starve_q;
        if (ahb_gnt || !bus.ahb_req || !bus.f_burst) starve_d = '0;
        else if (f_gnt && (starve_q < STARVE_LIM))    starve_d = starve_q + 1'b1;

        ahb_pend_d = ahb_gnt & ~bus.ahb_we;
        f_pend_d   = f_gnt & ~bus.f_we;
        f_lane_d   = f_gnt ? bus.f_addr[1:0] : f_lane_q;
        ahb_hold_d = ahb_pend_q ? bus.ram_rdata : ahb_hold_q;
        f_hold_d   = f_pend_q ? f_lane_data : f_hold_q;
    end

    always_comb begin
        bus.ahb_gnt    = ahb_gnt;
        bus.f_gnt      = f_gnt;
        bus.ahb_rvalid = ahb_pend_q;
        bus.f_rvalid   = f_pend_q;
        bus.ahb_rdata  = ahb_pend_q ? bus.ram_rdata : ahb_hold_q;
        bus.f_rdata    = f_pend_q ? f_lane_data : f_hold_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last_grant_q <= LAST_MFSM;
            starve_q     <= '0;
            ahb_pend_q   <= 1'b0;
            f_pend_q     <= 1'b0;
            f_lane_q     <= 2'd0;
            ahb_hold_q   <= 32'h0;
            f_hold_q     <= 8'h00;
        end else begin
            last_grant_q <= last_grant_d;
            starve_q     <= starve_d;
            ahb_pend_q   <= ahb_pend_d;
            f_pend_q     <= f_pend_d;
            f_lane_q     <= f_lane_d;
            ahb_hold_q   <= ahb_hold_d;
            f_hold_q     <= f_hold_d;
        end
    end

endmodule

// File: tb/tb_buf_port_arbiter.sv
// Self-checking bench for buf_port_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model with its own copy of the buffer.
module tb_buf_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;

    buf_port_arbiter_if bus();

    buf_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    // Buffer RAM environment; unwritten words read back a salted address hash.
    logic [31:0] salt;
    logic [31:0] ram_mem [256];
    bit          ram_vld [256];
    logic        lat_cs = 1'b0;
    logic        lat_we;
    logic [7:0]  lat_addr;
    logic [3:0]  lat_be;
    logic [31:0] lat_wdata;

    function automatic logic [31:0] seed(input int a);
        return (32'(a) * 32'h9E3779B1) ^ salt;
    endfunction

    always @(negedge HCLK) begin
        lat_cs    <= bus.ram_cs;
        lat_we    <= bus.ram_we;
        lat_addr  <= bus.ram_addr;
        lat_be    <= bus.ram_be;
        lat_wdata <= bus.ram_wdata;
    end

    always @(posedge HCLK) begin
        if (lat_cs === 1'b1) begin
            if (lat_we) begin
                logic [31:0] w;
                w = ram_vld[lat_addr] ? ram_mem[lat_addr] : seed(int'(lat_addr));
                for (int l = 0; l < 4; l++)
                    if (lat_be[l]) w[8*l +: 8] = lat_wdata[8*l +: 8];
                ram_mem[lat_addr] <= w;
                ram_vld[lat_addr] <= 1'b1;
            end else begin
                bus.ram_rdata <= ram_vld[lat_addr] ? ram_mem[lat_addr] : seed(int'(lat_addr));
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [256];
    int          m_last_f;
    int          m_starve;
    bit          m_pa, m_pf;
    logic [31:0] m_pa_data, m_ahb_hold;
    logic [7:0]  m_pf_data, m_f_hold;

    int n_cmp = 0;
    int n_err = 0;

    logic        e_ga, e_gf;
    logic        o_ga, o_gf, o_cs, o_we, o_arv, o_frv;
    logic [7:0]  o_addr, o_frd;
    logic [3:0]  o_be;
    logic [31:0] o_wdata, o_ard;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last_f   = 1;
        m_starve   = 0;
        m_pa       = 1'b0;
        m_pf       = 1'b0;
        m_ahb_hold = 32'h0;
        m_f_hold   = 8'h0;
    endtask

    task automatic apply_stimulus(input logic a_req, input logic a_we, input logic [7:0] a_addr,
                                  input logic [3:0] a_be, input logic [31:0] a_wdata,
                                  input logic fq, input logic fw, input logic [9:0] fa,
                                  input logic [7:0] fd, input logic fb);
        bus.ahb_req   = a_req;
        bus.ahb_we    = a_we;
        bus.ahb_addr  = a_addr;
        bus.ahb_be    = a_be;
        bus.ahb_wdata = a_wdata;
        bus.f_req     = fq;
        bus.f_we      = fw;
        bus.f_addr    = fa;
        bus.f_wdata   = fd;
        bus.f_burst   = fb;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_ahb_gnt"},    32'(bus.ahb_gnt),    0);
        check_output({tag, "_f_gnt"},      32'(bus.f_gnt),      0);
        check_output({tag, "_ahb_rvalid"}, 32'(bus.ahb_rvalid), 0);
        check_output({tag, "_f_rvalid"},   32'(bus.f_rvalid),   0);
        check_output({tag, "_ram_cs"},     32'(bus.ram_cs),     0);
        check_output({tag, "_ram_we"},     32'(bus.ram_we),     0);
        check_output({tag, "_ram_addr"},   32'(bus.ram_addr),   0);
        check_output({tag, "_ram_be"},     32'(bus.ram_be),     0);
        check_output({tag, "_ram_wdata"},  bus.ram_wdata,       0);
        check_output({tag, "_ahb_rdata"},  bus.ahb_rdata,       0);
        check_output({tag, "_f_rdata"},    32'(bus.f_rdata),    0);
    endtask

    // One clock: predict from the model, compare at the falling edge, advance the model.
    task automatic run_cycle();
        logic        e_cs, e_we;
        logic [7:0]  e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_ard;
        logic [7:0]  e_frd;
        int          lane, word;
        @(negedge HCLK);
        e_ga = 1'b0;
        e_gf = 1'b0;
        if (bus.ahb_req && bus.f_req) begin
            if (bus.f_burst) begin
                if (m_starve >= STARVE_MAX) e_ga = 1'b1;
                else                        e_gf = 1'b1;
            end else if (m_last_f != 0) e_ga = 1'b1;
            else                        e_gf = 1'b1;
        end else begin
            e_ga = bus.ahb_req;
            e_gf = bus.f_req;
        end
        e_cs = e_ga | e_gf;
        e_we = 1'b0; e_addr = 8'h0; e_be = 4'h0; e_wd = 32'h0;
        if (e_ga) begin
            e_we   = bus.ahb_we;
            e_addr = bus.ahb_addr;
            e_be   = bus.ahb_we ? bus.ahb_be : 4'h0;
            e_wd   = bus.ahb_wdata;
        end else if (e_gf) begin
            e_we   = bus.f_we;
            e_addr = 8'(bus.f_addr / 4);
            e_be   = bus.f_we ? 4'(1 << (bus.f_addr % 4)) : 4'h0;
            e_wd   = 32'(bus.f_wdata) * 32'h01010101;
        end
        e_ard = m_pa ? m_pa_data : m_ahb_hold;
        e_frd = m_pf ? m_pf_data : m_f_hold;

        o_ga = bus.ahb_gnt;   o_gf = bus.f_gnt;     o_cs = bus.ram_cs;  o_we = bus.ram_we;
        o_addr = bus.ram_addr; o_be = bus.ram_be;   o_wdata = bus.ram_wdata;
        o_arv = bus.ahb_rvalid; o_frv = bus.f_rvalid; o_ard = bus.ahb_rdata; o_frd = bus.f_rdata;

        check_output("ahb_gnt",    32'(o_ga),    32'(e_ga));
        check_output("f_gnt",      32'(o_gf),    32'(e_gf));
        check_output("ram_cs",     32'(o_cs),    32'(e_cs));
        check_output("ram_we",     32'(o_we),    32'(e_we));
        check_output("ram_addr",   32'(o_addr),  32'(e_addr));
        check_output("ram_be",     32'(o_be),    32'(e_be));
        check_output("ram_wdata",  o_wdata,      e_wd);
        check_output("ahb_rvalid", 32'(o_arv),   32'(m_pa));
        check_output("f_rvalid",   32'(o_frv),   32'(m_pf));
        check_output("ahb_rdata",  o_ard,        e_ard);
        check_output("f_rdata",    32'(o_frd),   32'(e_frd));

        @(posedge HCLK);
        if (m_pa) m_ahb_hold = m_pa_data;
        if (m_pf) m_f_hold   = m_pf_data;
        m_pa = 1'b0;
        m_pf = 1'b0;
        if (e_ga) begin
            m_last_f = 0;
            if (!bus.ahb_we) begin
                m_pa      = 1'b1;
                m_pa_data = ref_mem[bus.ahb_addr];
            end else begin
                for (int l = 0; l < 4; l++)
                    if (bus.ahb_be[l]) ref_mem[bus.ahb_addr][8*l +: 8] = bus.ahb_wdata[8*l +: 8];
            end
        end else if (e_gf) begin
            m_last_f = 1;
            lane = int'(bus.f_addr) % 4;
            word = int'(bus.f_addr) / 4;
            if (!bus.f_we) begin
                m_pf      = 1'b1;
                m_pf_data = 8'(ref_mem[word] >> (8 * lane));
            end else begin
                ref_mem[word] = (ref_mem[word] & ~(32'hFF << (8 * lane))) | (32'(bus.f_wdata) << (8 * lane));
            end
        end
        if (e_ga || !bus.ahb_req || !bus.f_burst) m_starve = 0;
        else if (e_gf && m_starve < STARVE_MAX)   m_starve = m_starve + 1;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          a_act, f_act;
        logic        a_we, f_we_r, burst;
        logic [7:0]  a_addr, f_wd;
        logic [3:0]  a_be;
        logic [31:0] a_wd;
        logic [9:0]  f_ad;

        salt = $urandom;
        for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
        model_reset();

        // Reset with both requesters active: nothing may reach the RAM.
        apply_stimulus(1, 0, 8'h21, 4'hF, 32'h0, 1, 0, 10'h084, 8'h0, 0);
        HRESETn = 1'b0;
        #12;
        check_reset_outputs("reset");

        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // Simultaneous reads after reset: AHB first, then flash, data returns back to back.
        run_cycle();
        check_output("conflict_ahb_first", 32'(o_ga), 1);
        apply_stimulus(0, 0, 8'h21, 4'hF, 32'h0, 1, 0, 10'h084, 8'h0, 0);
        run_cycle();
        check_output("conflict_f_second", 32'(o_gf), 1);
        check_output("conflict_ahb_rvalid", 32'(o_arv), 1);
        apply_stimulus(0, 0, 8'h00, 4'h0, 32'h0, 0, 0, 10'h000, 8'h0, 0);
        run_cycle();
        check_output("conflict_f_rvalid", 32'(o_frv), 1);
        check_output("conflict_ahb_rvalid_drop", 32'(o_arv), 0);

        // Flash byte write to the top lane, then read it back.
        apply_stimulus(0, 0, 8'h00, 4'h0, 32'h0, 1, 1, 10'h3F7, 8'hA5, 0);
        run_cycle();
        check_output("fwr_addr",  32'(o_addr), 32'h0000_00FD);
        check_output("fwr_be",    32'(o_be),   32'h0000_0008);
        check_output("fwr_wdata", o_wdata,     32'hA5A5_A5A5);
        apply_stimulus(0, 0, 8'h00, 4'h0, 32'h0, 1, 0, 10'h3F7, 8'h00, 0);
        run_cycle();
        apply_stimulus(0, 0, 8'h00, 4'h0, 32'h0, 0, 0, 10'h000, 8'h00, 0);
        run_cycle();
        check_output("frd_rvalid", 32'(o_frv), 1);
        check_output("frd_data",   32'(o_frd), 32'h0000_00A5);

        // Partial AHB write over all-ones, zero-lane write, then read back.
        apply_stimulus(1, 1, 8'h10, 4'hF, 32'hFFFF_FFFF, 0, 0, 10'h000, 8'h0, 0);
        run_cycle();
        apply_stimulus(1, 1, 8'h10, 4'h3, 32'h1234_5678, 0, 0, 10'h000, 8'h0, 0);
        run_cycle();
        apply_stimulus(1, 1, 8'h10, 4'h0, 32'hDEAD_BEEF, 0, 0, 10'h000, 8'h0, 0);
        run_cycle();
        check_output("be0_cs", 32'(o_cs), 1);
        check_output("be0_we", 32'(o_we), 1);
        check_output("be0_be", 32'(o_be), 0);
        apply_stimulus(1, 0, 8'h10, 4'hF, 32'h0, 0, 0, 10'h000, 8'h0, 0);
        run_cycle();
        apply_stimulus(0, 0, 8'h00, 4'h0, 32'h0, 0, 0, 10'h000, 8'h0, 0);
        run_cycle();
        check_output("ahb_merge_rvalid", 32'(o_arv), 1);
        check_output("ahb_merge_data",   o_ard,      32'hFFFF_5678);
        run_cycle();
        check_output("ahb_rdata_hold",   o_ard,      32'hFFFF_5678);

        // Burst with both sides held: F,F,F,F,A repeating; then burst drops at count 3.
        for (int i = 0; i < 13; i++) begin
            apply_stimulus(1, 0, 8'h10, 4'hF, 32'h0, 1, 0, 10'h3F5, 8'h0, 1);
            run_cycle();
            check_output($sformatf("burst_pattern_%0d", i), 32'(o_ga), (i % 5 == 4) ? 1 : 0);
        end
        apply_stimulus(1, 0, 8'h10, 4'hF, 32'h0, 1, 0, 10'h3F5, 8'h0, 0);
        run_cycle();
        check_output("burst_fall_rr_ahb", 32'(o_ga), 1);

        // Reset pulse between an AHB read grant and its data return.
        apply_stimulus(1, 0, 8'h10, 4'hF, 32'h0, 0, 0, 10'h000, 8'h0, 0);
        run_cycle();
        check_output("rstpulse_grant", 32'(o_ga), 1);
        apply_stimulus(1, 0, 8'h10, 4'hF, 32'h0, 1, 0, 10'h001, 8'h0, 0);
        HRESETn = 1'b0;
        #1;
        check_reset_outputs("rstpulse");
        #1;
        HRESETn = 1'b1;
        model_reset();
        run_cycle();
        check_output("rstpulse_no_rvalid", 32'(o_arv), 0);
        check_output("rstpulse_ahb_wins",  32'(o_ga),  1);

        // Random traffic: requesters hold each transaction until it is granted.
        a_act = 1'b0; f_act = 1'b0; burst = 1'b0;
        a_we = 1'b0; a_addr = 8'h0; a_be = 4'h0; a_wd = 32'h0;
        f_we_r = 1'b0; f_ad = 10'h0; f_wd = 8'h0;
        for (int c = 0; c < 600; c++) begin
            if (!a_act && $urandom_range(99) < 55) begin
                a_act  = 1'b1;
                a_we   = 1'($urandom_range(1));
                a_addr = 8'($urandom_range(15));
                a_be   = 4'($urandom_range(15));
                a_wd   = $urandom;
            end
            if (!f_act && $urandom_range(99) < 60) begin
                f_act  = 1'b1;
                f_we_r = 1'($urandom_range(1));
                f_ad   = 10'($urandom_range(63));
                f_wd   = 8'($urandom_range(255));
            end
            if ($urandom_range(99) < 6) burst = ~burst;
            apply_stimulus(a_act, a_we, a_addr, a_be, a_wd, f_act, f_we_r, f_ad, f_wd, burst);
            run_cycle();
            if (e_ga) a_act = 1'b0;
            if (e_gf) f_act = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/buf_port_arbiter.md
BUF_PORT_ARBITER -- requirements
Module: buf_port_arbiter

Interface
REQ-001 SHALL have ports: HCLK  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: HRESETn  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: ahb_req in 1 AHB-side access request; ahb_we in 1 write; ahb_addr in 8 word address (byte addr[9:2]); ahb_be in 4 byte-lane enables; ahb_wdata in 32.
REQ-004 SHALL have ports: ahb_gnt out 1 access accepted this cycle; ahb_rvalid out 1 read data valid; ahb_rdata out 32.
REQ-005 SHALL have ports: f_req in 1 flash-FSM request; f_we in 1; f_addr in 10 byte address; f_wdata in 8; f_gnt out 1; f_rvalid out 1; f_rdata out 8.
REQ-006 SHALL have ports: f_burst in 1 flash-FSM page transfer in progress (raises MFSM priority).
REQ-007 SHALL have ports: ram_cs out 1; ram_we out 1; ram_addr out 8; ram_be out 4; ram_wdata out 32; ram_rdata in 32 (single-port 256x32 buffer, read data one cycle after ram_cs).
REQ-008 SHALL have parameter: STARVE_MAX, default 4, max consecutive MFSM grants under f_burst while ahb_req pending.

Function
REQ-009 SHALL grant at most one requester per cycle; gnt is combinational from req and registered arbiter state, same cycle as ram_cs.
REQ-010 SHALL drive ram_cs=gnt_any, ram_we, ram_addr, ram_be, ram_wdata from the granted requester in the grant cycle; all RAM outputs 0 when no grant.
REQ-011 MFSM mapping SHALL be ram_addr=f_addr[9:2], ram_be=one-hot lane 1<<f_addr[1:0] (reads: 4'b0000 on ram_be), ram_wdata=f_wdata replicated on all four lanes.
REQ-012 AHB writes SHALL pass ahb_be unchanged; AHB write with ahb_be=0 SHALL still be granted and ram_cs asserted with ram_we=1, no lane written.
REQ-013 Arbitration, f_burst=0: round-robin; on simultaneous request grant the side not granted last; last_grant reset value = MFSM (AHB wins first conflict).
REQ-014 Arbitration, f_burst=1: MFSM wins conflicts; starve counter increments on each MFSM grant while ahb_req=1; when counter equals STARVE_MAX, next conflict goes to AHB and counter clears.
REQ-015 Starve counter SHALL clear on any AHB grant, on ahb_req=0, or on f_burst falling; it SHALL saturate, never wrap.
REQ-016 Single requester SHALL be granted immediately regardless of f_burst or counter.
REQ-017 Requesters hold req/addr/data stable until gnt; arbiter SHALL NOT queue; ungranted request is retried next cycle by the requester.
REQ-018 Read return: one cycle after a granted read, the owning side's rvalid=1 for exactly one cycle; ahb_rdata=ram_rdata; f_rdata=lane of ram_rdata selected by registered f_addr[1:0].
REQ-019 Back-to-back grants SHALL be supported every cycle, including read-then-read on alternating sides; rvalid owner tag is registered per grant.
REQ-020 Read data outputs SHALL hold last returned value when rvalid=0.
REQ-021 A write does not produce rvalid.

Reset
REQ-022 On HRESETn=0, asynchronously: ahb_gnt, f_gnt, ahb_rvalid, f_rvalid, ram_cs, ram_we = 0; ram_addr, ram_be, ram_wdata, ahb_rdata, f_rdata = 0; last_grant=MFSM; starve counter=0; pending-read tag cleared.
REQ-023 Reset asserted between grant and data return SHALL cancel the return: no rvalid after deassertion.
REQ-024 Grants SHALL be possible on the first rising edge after HRESETn deasserts.

Verification
REQ-025 Reset, then ahb_req=1 and f_req=1 same cycle, both reads, f_burst=0 -> ahb_gnt first, f_gnt next cycle, ahb_rvalid then f_rvalid on consecutive cycles.
REQ-026 f_we=1, f_addr=10'h3F7, f_wdata=8'hA5 -> ram_addr=8'hFD, ram_be=4'b1000, ram_wdata=32'hA5A5A5A5; follow-up read of 10'h3F7 returns f_rdata=8'hA5 with f_rvalid.
REQ-027 f_burst=1, f_req and ahb_req held high continuously, STARVE_MAX=4 -> grant pattern F,F,F,F,A repeating.
REQ-028 AHB write ahb_addr=8'h10, ahb_be=4'b0011, ahb_wdata=32'h12345678 over prior 32'hFFFFFFFF -> AHB read of 8'h10 returns 32'hFFFF5678.
REQ-029 Granted AHB read, HRESETn pulsed low before next edge -> ahb_rvalid stays 0, all outputs 0, next conflict granted to AHB.
REQ-030 f_burst falls with starve counter at 3, conflict next cycle -> round-robin applies (AHB granted, since MFSM granted last).
